// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: sequential fetch, prioritised trap/mret/branch redirects,
// single pending-redirect slot while the instruction memory or a hazard holds the pc.
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC    = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        trap_req,
  input  logic [31:0] trap_vec,
  input  logic        mret_req,
  input  logic [31:0] mret_epc,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic        flush,
  output logic        redirect
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned PRIO_W = 2;
  localparam int unsigned CNT_W  = 2;

  localparam logic [PRIO_W-1:0] PRIO_NONE = PRIO_W'(0);
  localparam logic [PRIO_W-1:0] PRIO_BR   = PRIO_W'(1);
  localparam logic [PRIO_W-1:0] PRIO_MRET = PRIO_W'(2);
  localparam logic [PRIO_W-1:0] PRIO_TRAP = PRIO_W'(3);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {BOOT, FETCH, REDIR_WAIT, FLUSH} state_t;

  state_t            state;
  logic [PRIO_W-1:0] pend_prio;
  logic [XLEN-1:0]   pend_tgt;
  logic [CNT_W-1:0]  cnt;

  logic [PRIO_W-1:0] arr_prio;
  logic [XLEN-1:0]   arr_tgt;
  logic              arriving;
  logic              go;
  logic              upgrade;
  logic [XLEN-1:0]   eff_tgt;

  // Select the highest-priority redirect presented this cycle.
  always_comb begin
    arr_prio = PRIO_NONE;
    arr_tgt  = br_target;
    if (trap_req) begin
      arr_prio = PRIO_TRAP;
      arr_tgt  = trap_vec;
    end else if (mret_req) begin
      arr_prio = PRIO_MRET;
      arr_tgt  = mret_epc;
    end else if (br_taken) begin
      arr_prio = PRIO_BR;
      arr_tgt  = br_target;
    end
  end

  assign arriving = (arr_prio != PRIO_NONE) && (state != BOOT);
  assign go       = imem_ready && !stall;
  assign upgrade  = arriving && (arr_prio > pend_prio);
  assign eff_tgt  = upgrade ? arr_tgt : pend_tgt;

  // Squash covers the arrival cycle itself, so it cannot wait for a clock edge.
  assign flush = arriving || (state == REDIR_WAIT) || (state == FLUSH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= BOOT;
      pc        <= RESET_VEC;
      imem_req  <= 1'b0;
      redirect  <= 1'b0;
      pend_prio <= PRIO_NONE;
      pend_tgt  <= XLEN'(0);
      cnt       <= CNT_W'(0);
    end else begin
      redirect <= 1'b0;
      case (state)
        BOOT: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH, FLUSH: begin
          if (arriving) begin
            if (go) begin
              pc       <= arr_tgt;
              redirect <= 1'b1;
              state    <= FLUSH;
              cnt      <= CNT_LOAD;
            end else begin
              pend_prio <= arr_prio;
              pend_tgt  <= arr_tgt;
              state     <= REDIR_WAIT;
            end
          end else if (!stall) begin
            if (imem_ready) pc <= pc + XLEN'(4);
            if (state == FLUSH) begin
              if (cnt == CNT_W'(0)) state <= FETCH;
              else                  cnt   <= cnt - CNT_W'(1);
            end
          end
        end
        REDIR_WAIT: begin
          if (go) begin
            pc        <= eff_tgt;
            redirect  <= 1'b1;
            pend_prio <= PRIO_NONE;
            state     <= FLUSH;
            cnt       <= CNT_LOAD;
          end else if (upgrade) begin
            pend_prio <= arr_prio;
            pend_tgt  <= arr_tgt;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule
